// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the AES decryption datapath.
// Provides the FSM state enum, column index type and GF(2^8) xtime.
package aes_dec_pkg;

  localparam int STATE_W  = 128;
  localparam int COL_W    = 32;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } imc_state_t;

  typedef logic [1:0] col_idx_t;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_gf_mul.sv
// Constant GF(2^8) multiplier: p = K * a, K is a 4-bit constant.
// Ports: a (8-bit operand in), p (8-bit product out).
module aes_gf_mul
  import aes_dec_pkg::*;
#(
  parameter logic [3:0] K = 4'd9
) (
  input  logic [7:0] a,
  output logic [7:0] p
);

  logic [7:0] t;

  always_comb begin
    p = 8'h00;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (K[i]) p = p ^ t;
      t = xtime(t);
    end
  end

endmodule

// File: rtl/inv_mix_columns_seq_col.sv
// Combinational InvMixColumns on a single 32-bit column.
// Ports: col (a0 in [31:24] .. a3 in [7:0]), res (same byte order).
module inv_mix_column
  import aes_dec_pkg::*;
(
  input  logic [COL_W-1:0] col,
  output logic [COL_W-1:0] res
);

  logic [7:0] a   [4];
  logic [7:0] p9  [4];
  logic [7:0] p11 [4];
  logic [7:0] p13 [4];
  logic [7:0] p14 [4];

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign a[i] = col[31-8*i -: 8];
    aes_gf_mul #(.K(4'd9))  u_m9  (.a(a[i]), .p(p9[i]));
    aes_gf_mul #(.K(4'd11)) u_m11 (.a(a[i]), .p(p11[i]));
    aes_gf_mul #(.K(4'd13)) u_m13 (.a(a[i]), .p(p13[i]));
    aes_gf_mul #(.K(4'd14)) u_m14 (.a(a[i]), .p(p14[i]));
  end

  assign res[31:24] = p14[0] ^ p11[1] ^ p13[2] ^ p9[3];
  assign res[23:16] = p9[0]  ^ p14[1] ^ p11[2] ^ p13[3];
  assign res[15:8]  = p13[0] ^ p9[1]  ^ p14[2] ^ p11[3];
  assign res[7:0]   = p11[0] ^ p13[1] ^ p9[2]  ^ p14[3];

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential InvMixColumns: one column per cycle, valid/ready both sides.
// Ports: clk, rst_n, in_valid/in_ready/in_state/in_bypass, out_valid/out_ready/out_state.
module inv_mix_columns_seq
  import aes_dec_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic               in_bypass,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state
);

  imc_state_t         st_q, st_d;
  col_idx_t           col_q, col_d;
  logic [STATE_W-1:0] reg_q, reg_d;
  logic [COL_W-1:0]   cur_col;
  logic [COL_W-1:0]   mix_col;
  int                 hi;

  assign hi      = STATE_W - 1 - COL_W * int'(col_q);
  assign cur_col = reg_q[hi -: COL_W];

  inv_mix_column u_col (
    .col (cur_col),
    .res (mix_col)
  );

  assign in_ready  = (st_q == IDLE);
  assign out_valid = (st_q == DONE);
  assign out_state = reg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      col_q <= '0;
      reg_q <= '0;
    end else begin
      st_q  <= st_d;
      col_q <= col_d;
      reg_q <= reg_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    col_d = col_q;
    reg_d = reg_q;
    unique case (st_q)
      IDLE: begin
        if (in_valid) begin
          reg_d = in_state;
          col_d = '0;
          st_d  = in_bypass ? DONE : BUSY;
        end
      end
      BUSY: begin
        reg_d[hi -: COL_W] = mix_col;
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) st_d = DONE;
      end
      DONE: begin
        if (out_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

endmodule
